// File: rtl/hram_pkg.sv
// Shared widths and types for the HyperRAM command arbiter.
package hram_pkg;

    localparam int HRAM_ADDR_W = 12;
    localparam int HRAM_DATA_W = 16;

    typedef logic port_id_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/hram_tag_fifo.sv
// In-order FIFO of port ids, one entry per read accepted by the controller.
module hram_tag_fifo
    import hram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  port_id_t push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output port_id_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    port_id_t             mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W:0]       count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A push at full is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hram_arbiter.sv
// Round-robin sharing of the hyperram_ctrl command port between two clients,
// with read data routed back through an in-order tag FIFO.
module hram_arbiter
    import hram_pkg::*;
#(
    parameter int ADDR_W    = HRAM_ADDR_W,
    parameter int DATA_W    = HRAM_DATA_W,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rd_vld,
    input  logic              m1_req,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_req,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    input  logic              sram_ready,
    input  logic              sram_rd_data_vld,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              err_orphan
);

    arb_state_t        state_reg;
    port_id_t          last_grant_reg;
    port_id_t          gnt_id_reg;
    port_id_t          winner;
    logic              grant;
    logic [1:0]        ack_reg;
    logic [1:0]        rd_vld_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              sram_req_reg;
    logic              sram_rd_reg;
    logic [ADDR_W-1:0] sram_addr_reg;
    logic [DATA_W-1:0] sram_wr_data_reg;
    logic              err_orphan_reg;

    logic [1:0]        req_vec;
    logic [1:0]        rd_vec;
    logic [1:0]        eligible;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    port_id_t          fifo_head;

    assign req_vec      = {m1_req, m0_req};
    assign rd_vec       = {m1_rd, m0_rd};
    assign addr_vec[0]  = m0_addr;
    assign addr_vec[1]  = m1_addr;
    assign wdata_vec[0] = m0_wdata;
    assign wdata_vec[1] = m1_wdata;

    // Reads need a free tag slot; occupancy is taken before any same-cycle pop.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = req_vec[gi] && (!rd_vec[gi] || !fifo_full);
        end
    endgenerate

    always_comb begin
        grant  = |eligible;
        winner = 1'b0;
        if (&eligible) begin
            winner = ~last_grant_reg;
        end else if (eligible[1]) begin
            winner = 1'b1;
        end
    end

    assign fifo_push = (state_reg == ISSUE) && sram_ready && sram_rd_reg;

    hram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (gnt_id_reg),
        .pop     (sram_rd_data_vld),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_grant_reg   <= 1'b1;
            gnt_id_reg       <= 1'b0;
            ack_reg          <= '0;
            rd_vld_reg       <= '0;
            rd_data_reg      <= '0;
            sram_req_reg     <= 1'b0;
            sram_rd_reg      <= 1'b0;
            sram_addr_reg    <= '0;
            sram_wr_data_reg <= '0;
            err_orphan_reg   <= 1'b0;
        end else begin
            ack_reg    <= '0;
            rd_vld_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        sram_req_reg     <= 1'b1;
                        sram_rd_reg      <= rd_vec[winner];
                        sram_addr_reg    <= addr_vec[winner];
                        sram_wr_data_reg <= wdata_vec[winner];
                        gnt_id_reg       <= winner;
                        last_grant_reg   <= winner;
                        state_reg        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sram_ready) begin
                        sram_req_reg        <= 1'b0;
                        ack_reg[gnt_id_reg] <= 1'b1;
                        state_reg           <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Strobes with nothing outstanding are dropped and flagged.
            if (sram_rd_data_vld) begin
                if (!fifo_empty) begin
                    rd_vld_reg[fifo_head] <= 1'b1;
                    rd_data_reg           <= sram_rd_data;
                end else begin
                    err_orphan_reg <= 1'b1;
                end
            end
        end
    end

    assign m0_ack       = ack_reg[0];
    assign m1_ack       = ack_reg[1];
    assign m0_rd_vld    = rd_vld_reg[0];
    assign m1_rd_vld    = rd_vld_reg[1];
    assign rd_data      = rd_data_reg;
    assign sram_req     = sram_req_reg;
    assign sram_rd      = sram_rd_reg;
    assign sram_addr    = sram_addr_reg;
    assign sram_wr_data = sram_wr_data_reg;
    assign err_orphan   = err_orphan_reg;

endmodule

// File: tb/tb_hram_arbiter.sv
// Directed and randomized checks of hram_arbiter against a queue-based model.
module tb_hram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m_req = '0;
    logic [1:0]  m_rd = '0;
    logic [11:0] m_addr [2];
    logic [15:0] m_wdata [2];
    logic        sram_ready = 1'b1;
    logic        strobe = 1'b0;
    logic [15:0] strobe_data = '0;

    logic        m0_ack, m1_ack, m0_rd_vld, m1_rd_vld;
    logic [15:0] rd_data;
    logic        sram_req, sram_rd;
    logic [11:0] sram_addr;
    logic [15:0] sram_wr_data;
    logic        err_orphan;

    int total = 0;
    int bad = 0;

    int          order [$];
    int          q [$];
    int          k [2];
    int          wait_cnt [2];
    bit          busy [2];
    bit          got0, got1;
    bit          pend_vld, prev_hs, prev_hold;
    int          pend_p;
    logic [15:0] pend_d;
    logic        prev_rd;
    logic [11:0] prev_addr;
    logic [15:0] prev_wdata;

    hram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_req           (m_req[0]),
        .m0_rd            (m_rd[0]),
        .m0_addr          (m_addr[0]),
        .m0_wdata         (m_wdata[0]),
        .m0_ack           (m0_ack),
        .m0_rd_vld        (m0_rd_vld),
        .m1_req           (m_req[1]),
        .m1_rd            (m_rd[1]),
        .m1_addr          (m_addr[1]),
        .m1_wdata         (m_wdata[1]),
        .m1_ack           (m1_ack),
        .m1_rd_vld        (m1_rd_vld),
        .rd_data          (rd_data),
        .sram_req         (sram_req),
        .sram_rd          (sram_rd),
        .sram_addr        (sram_addr),
        .sram_wr_data     (sram_wr_data),
        .sram_ready       (sram_ready),
        .sram_rd_data_vld (strobe),
        .sram_rd_data     (strobe_data),
        .err_orphan       (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic ack_of(input int p);
        return (p != 0) ? m1_ack : m0_ack;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        m_req = '0;
        m_rd = '0;
        strobe = 1'b0;
        sram_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raise a request, wait (bounded) for its ack, then drop it in the ack cycle.
    task automatic issue(input int p, input logic rd, input logic [11:0] a, input logic [15:0] d);
        bit seen;
        seen = 1'b0;
        m_req[p] = 1'b1;
        m_rd[p] = rd;
        m_addr[p] = a;
        m_wdata[p] = d;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (ack_of(p)) seen = 1'b1;
        end
        m_req[p] = 1'b0;
        chk("issue_ack", 32'(seen), 1);
        $display("cmd port=%0d rd=%0b addr=0x%03h wdata=0x%04h", p, rd, a, d);
    endtask

    initial begin
        m_addr[0] = '0; m_addr[1] = '0;
        m_wdata[0] = '0; m_wdata[1] = '0;

        // reset state
        do_reset();
        chk("rst_sram_req", 32'(sram_req), 0);
        chk("rst_sram_rd", 32'(sram_rd), 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_sram_wr_data", 32'(sram_wr_data), 0);
        chk("rst_acks", 32'({m1_ack, m0_ack}), 0);
        chk("rst_rd_vld", 32'({m1_rd_vld, m0_rd_vld}), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_err_orphan", 32'(err_orphan), 0);

        // single write on port 0, ready tied high
        m_req[0] = 1'b1; m_rd[0] = 1'b0; m_addr[0] = 12'h010; m_wdata[0] = 16'hAA55;
        tick();
        chk("w0_sram_req", 32'(sram_req), 1);
        chk("w0_sram_rd", 32'(sram_rd), 0);
        chk("w0_sram_addr", 32'(sram_addr), 32'h010);
        chk("w0_sram_wdata", 32'(sram_wr_data), 32'hAA55);
        chk("w0_ack_early", 32'(m0_ack), 0);
        tick();
        chk("w0_sram_req_drop", 32'(sram_req), 0);
        chk("w0_ack", 32'(m0_ack), 1);
        m_req[0] = 1'b0;
        tick();
        chk("w0_ack_once", 32'(m0_ack), 0);
        chk("w0_no_req", 32'(sram_req), 0);
        $display("cmd port=0 rd=0 addr=0x010 wdata=0xaa55");

        // round-robin over 8 continuous writes, starting from reset
        do_reset();
        order.delete();
        k[0] = 0; k[1] = 0;
        m_req = 2'b11; m_rd = 2'b00;
        m_addr[0] = 12'h100; m_addr[1] = 12'h200;
        m_wdata[0] = 16'h1000; m_wdata[1] = 16'h2000;
        for (int c = 0; c < 80 && order.size() < 8; c++) begin
            tick();
            chk("alt_one_ack", 32'(m0_ack & m1_ack), 0);
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p)) begin
                    order.push_back(p);
                    $display("grant port=%0d addr=0x%03h", p, m_addr[p]);
                    k[p]++;
                    if (k[p] < 4) m_addr[p] = m_addr[p] + 12'd1;
                    else m_req[p] = 1'b0;
                end
            end
        end
        chk("alt_count", 32'(order.size()), 8);
        foreach (order[i]) chk("alt_order", 32'(order[i]), 32'(i % 2));
        m_req = '0;

        // tag FIFO full blocks a 5th read but not a write
        do_reset();
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 12'(12'h300 + i), 16'h0);
        m_req[1] = 1'b1; m_rd[1] = 1'b1; m_addr[1] = 12'h304;
        m_req[0] = 1'b1; m_rd[0] = 1'b0; m_addr[0] = 12'h050; m_wdata[0] = 16'h5A5A;
        got0 = 1'b0; got1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (m0_ack) begin got0 = 1'b1; m_req[0] = 1'b0; end
            if (m1_ack) got1 = 1'b1;
        end
        chk("full_p0_write", 32'(got0), 1);
        chk("full_p1_blocked", 32'(got1), 0);
        strobe = 1'b1; strobe_data = 16'h1234;
        tick();
        strobe = 1'b0;
        chk("full_m1_rd_vld", 32'(m1_rd_vld), 1);
        chk("full_m0_rd_vld", 32'(m0_rd_vld), 0);
        chk("full_rd_data", 32'(rd_data), 32'h1234);
        $display("read return port=1 data=0x%04h", rd_data);
        got1 = 1'b0;
        for (int c = 0; c < 8 && !got1; c++) begin
            tick();
            if (m1_ack) got1 = 1'b1;
        end
        m_req[1] = 1'b0;
        chk("full_p1_issued", 32'(got1), 1);

        // interleaved reads p0,p1,p0 returned in order
        do_reset();
        issue(0, 1'b1, 12'h400, 16'h0);
        issue(1, 1'b1, 12'h401, 16'h0);
        issue(0, 1'b1, 12'h402, 16'h0);
        strobe = 1'b1; strobe_data = 16'h0001;
        tick();
        chk("il1_m0", 32'(m0_rd_vld), 1);
        chk("il1_m1", 32'(m1_rd_vld), 0);
        chk("il1_data", 32'(rd_data), 32'h0001);
        strobe_data = 16'h0002;
        tick();
        chk("il2_m0", 32'(m0_rd_vld), 0);
        chk("il2_m1", 32'(m1_rd_vld), 1);
        chk("il2_data", 32'(rd_data), 32'h0002);
        strobe_data = 16'h0003;
        tick();
        strobe = 1'b0;
        chk("il3_m0", 32'(m0_rd_vld), 1);
        chk("il3_m1", 32'(m1_rd_vld), 0);
        chk("il3_data", 32'(rd_data), 32'h0003);
        tick();
        chk("il_done", 32'({m1_rd_vld, m0_rd_vld}), 0);
        $display("interleaved returns checked");

        // controller stalls for 5 cycles
        sram_ready = 1'b0;
        m_req[0] = 1'b1; m_rd[0] = 1'b0; m_addr[0] = 12'h055; m_wdata[0] = 16'h1357;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(sram_req), 1);
            chk("stall_fields", {3'b0, sram_rd, sram_addr, sram_wr_data}, {3'b0, 1'b0, 12'h055, 16'h1357});
            chk("stall_no_ack", 32'(m0_ack), 0);
            tick();
        end
        sram_ready = 1'b1;
        tick();
        chk("stall_ack", 32'(m0_ack), 1);
        chk("stall_req_drop", 32'(sram_req), 0);
        m_req[0] = 1'b0;
        $display("stall cmd port=0 addr=0x055 acked");

        // reset while ISSUE with two reads outstanding
        do_reset();
        issue(0, 1'b1, 12'h500, 16'h0);
        issue(0, 1'b1, 12'h501, 16'h0);
        sram_ready = 1'b0;
        m_req[1] = 1'b1; m_rd[1] = 1'b0; m_addr[1] = 12'h600; m_wdata[1] = 16'h6666;
        tick();
        chk("mr_issue", 32'(sram_req), 1);
        reset = 1'b1;
        tick();
        chk("mr_req_drop", 32'(sram_req), 0);
        reset = 1'b0;
        m_req = '0;
        sram_ready = 1'b1;
        strobe = 1'b1; strobe_data = 16'hBEEF;
        tick();
        strobe = 1'b0;
        chk("mr_no_rd_vld", 32'({m1_rd_vld, m0_rd_vld}), 0);
        chk("mr_orphan", 32'(err_orphan), 1);
        tick();
        tick();
        chk("mr_orphan_sticky", 32'(err_orphan), 1);
        $display("reset mid-issue checked");

        // randomized traffic against the scoreboard
        do_reset();
        chk("rnd_orphan_clear", 32'(err_orphan), 0);
        q.delete();
        busy[0] = 1'b0; busy[1] = 1'b0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        pend_vld = 1'b0; pend_p = 0; pend_d = '0;
        prev_hs = 1'b0; prev_hold = 1'b0;
        prev_rd = 1'b0; prev_addr = '0; prev_wdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            chk("rnd_vld0", 32'(m0_rd_vld), 32'(pend_vld && pend_p == 0));
            chk("rnd_vld1", 32'(m1_rd_vld), 32'(pend_vld && pend_p == 1));
            if (pend_vld) chk("rnd_rdata", 32'(rd_data), 32'(pend_d));
            chk("rnd_one_ack", 32'(m0_ack & m1_ack), 0);
            chk("rnd_hs_ack", 32'(m0_ack | m1_ack), 32'(prev_hs));
            if (prev_hold)
                chk("rnd_hold", {2'b0, sram_req, sram_rd, sram_addr, sram_wr_data},
                    {2'b0, 1'b1, prev_rd, prev_addr, prev_wdata});
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p)) begin
                    chk("rnd_ack_busy", 32'(busy[p]), 1);
                    chk("rnd_ack_fields", {3'b0, prev_rd, prev_addr, prev_wdata},
                        {3'b0, m_rd[p], m_addr[p], m_wdata[p]});
                    $display("rnd ack port=%0d rd=%0b addr=0x%03h", p, m_rd[p], m_addr[p]);
                    if (m_rd[p]) begin
                        q.push_back(p);
                        chk("rnd_tag_bound", 32'(q.size() <= 4), 1);
                    end
                    busy[p] = 1'b0;
                    m_req[p] = 1'b0;
                    wait_cnt[p] = 0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!busy[p] && $urandom_range(0, 2) == 0) begin
                    busy[p] = 1'b1;
                    m_req[p] = 1'b1;
                    m_rd[p] = 1'($urandom_range(0, 1));
                    m_addr[p] = 12'($urandom);
                    m_wdata[p] = 16'($urandom);
                end else if (busy[p]) begin
                    wait_cnt[p]++;
                    chk("rnd_starve", 32'(wait_cnt[p] <= 150), 1);
                end
            end
            pend_vld = 1'b0;
            strobe = 1'b0;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                strobe = 1'b1;
                strobe_data = 16'($urandom);
                pend_vld = 1'b1;
                pend_p = q.pop_front();
                pend_d = strobe_data;
            end
            sram_ready = ($urandom_range(0, 3) != 0);
            prev_hs = sram_req && sram_ready;
            prev_hold = sram_req && !sram_ready;
            prev_rd = sram_rd;
            prev_addr = sram_addr;
            prev_wdata = sram_wr_data;
        end
        tick();
        chk("rnd_last_vld0", 32'(m0_rd_vld), 32'(pend_vld && pend_p == 0));
        chk("rnd_last_vld1", 32'(m1_rd_vld), 32'(pend_vld && pend_p == 1));
        chk("rnd_no_orphan", 32'(err_orphan), 0);
        m_req = '0;
        strobe = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
